// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: button-controlled IDLE/RUN/PAUSE FSM driving four LEDs through a prescaled step tick.
// Optional press debounce filter is enabled by defining LED_SEQ_DEBOUNCE_EN.
module led_pattern_sequencer #(
    parameter int DIV_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [1:0] rate_sel,
    output logic [3:0] Led,
    output logic       tick,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    if (DIV_WIDTH < 8 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("led_pattern_sequencer: DIV_WIDTH must be >= 8 and DEBOUNCE_CYCLES >= 1");
    end

    logic                 btn_meta;
    logic                 btn_sync;
    logic                 btn_filt;
    logic                 btn_prev;
    logic [1:0]           sync_valid;
    logic                 armed;
    logic                 press;
    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [1:0]           mode_q;
    logic                 dir_up;
    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] terminal;

    // armed only sets once the synchronizer holds a real low sample, so a
    // button already held across reset release is not taken as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            btn_prev   <= 1'b0;
            sync_valid <= 2'b00;
            armed      <= 1'b0;
        end else begin
            btn_meta   <= btn;
            btn_sync   <= btn_meta;
            btn_prev   <= btn_filt;
            sync_valid <= {sync_valid[0], 1'b1};
            if (sync_valid[1] && !btn_sync)
                armed <= 1'b1;
        end
    end

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_count;
    logic            db_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_count <= '0;
            db_level <= 1'b0;
        end else if (!btn_sync) begin
            db_count <= '0;
            db_level <= 1'b0;
        end else if (db_count == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level <= 1'b1;
        end else begin
            db_count <= db_count + DB_W'(1);
        end
    end

    assign btn_filt = db_level;
`else
    assign btn_filt = btn_sync;
`endif

    assign press    = btn_filt & ~btn_prev & armed;
    assign terminal = {DIV_WIDTH{1'b1}} >> {rate_sel, 1'b0};
    assign tick     = (state == RUN) && (count >= terminal);

    always_comb begin
        next_state = state;
        if (stop) begin
            next_state = IDLE;
        end else if (press) begin
            case (state)
                IDLE:    next_state = RUN;
                RUN:     next_state = PAUSE;
                PAUSE:   next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    function automatic logic [3:0] init_pattern(input logic [1:0] m);
        case (m)
            2'd0:    return 4'b1111;
            2'd3:    return 4'b0000;
            default: return 4'b0001;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            if (next_state == IDLE)
                count <= '0;
            else if (state == RUN)
                count <= tick ? '0 : count + DIV_WIDTH'(1);
        end
    end

    // A tick after a mode change reloads the new mode's start pattern rather than stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Led    <= 4'b0000;
            mode_q <= 2'd0;
            dir_up <= 1'b1;
        end else if (next_state == IDLE) begin
            Led <= 4'b0000;
        end else if (state == IDLE) begin
            mode_q <= mode;
            Led    <= init_pattern(mode);
            dir_up <= 1'b1;
        end else if (tick) begin
            if (mode != mode_q) begin
                mode_q <= mode;
                Led    <= init_pattern(mode);
                dir_up <= 1'b1;
            end else begin
                case (mode_q)
                    2'd0: Led <= ~Led;
                    2'd1: Led <= {Led[2:0], Led[3]};
                    2'd2: begin
                        if (dir_up) begin
                            if (Led[3]) begin
                                Led    <= 4'b0100;
                                dir_up <= 1'b0;
                            end else begin
                                Led <= Led << 1;
                            end
                        end else if (Led[0]) begin
                            Led    <= 4'b0010;
                            dir_up <= 1'b1;
                        end else begin
                            Led <= Led >> 1;
                        end
                    end
                    default: Led <= Led + 4'd1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: a step-indexed reference model predicts LEDs, busy and each tick.
// Works with or without LED_SEQ_DEBOUNCE_EN defined.
module tb_led_pattern_sequencer;

    localparam int DIV_WIDTH       = 8;
    localparam int DEBOUNCE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       stop;
    logic [1:0] mode;
    logic [1:0] rate_sel;
    logic [3:0] Led;
    logic       tick;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: state 0 idle, 1 run, 2 pause; LEDs derived from steps taken since the last pattern load
    int         m_state     = 0;
    int         m_cnt       = 0;
    int         m_mode      = 0;
    int         m_step      = 0;
    int         m_edge      = 0;
    int         m_first_low = -1;
    int         m_next;
    bit         m_tick;
    bit         m_press;
    bit         btn_hist[$];
    logic [3:0] sb_q[$];

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .DIV_WIDTH      (DIV_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .stop    (stop),
        .mode    (mode),
        .rate_sel(rate_sel),
        .Led     (Led),
        .tick    (tick),
        .busy    (busy)
    );

    function automatic int term_of(input logic [1:0] rs);
        return ((1 << DIV_WIDTH) - 1) >> (2 * int'(rs));
    endfunction

    function automatic logic [3:0] pattern_of(input int md, input int st);
        logic [3:0] bounce [0:5];
        bounce = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2};
        case (md)
            0:       return (st % 2 == 1) ? 4'd0 : 4'd15;
            1:       return 4'(1 << (st % 4));
            2:       return bounce[st % 6];
            default: return 4'(st % 16);
        endcase
    endfunction

    function automatic logic [3:0] model_led();
        return (m_state == 0) ? 4'd0 : pattern_of(m_mode, m_step);
    endfunction

    function automatic bit btn_at(input int i);
        if (i >= 1 && i <= btn_hist.size())
            return btn_hist[i - 1];
        return 1'b0;
    endfunction

    // Filtered button level during the cycle following edge n
    function automatic bit filt_after(input int n);
`ifdef LED_SEQ_DEBOUNCE_EN
        for (int j = n - 1 - DEBOUNCE_CYCLES; j <= n - 2; j++)
            if (!btn_at(j))
                return 1'b0;
        return 1'b1;
`else
        return btn_at(n - 1);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state     = 0;
            m_cnt       = 0;
            m_mode      = 0;
            m_step      = 0;
            m_edge      = 0;
            m_first_low = -1;
            btn_hist.delete();
            sb_q.delete();
        end else begin
            m_edge++;
            btn_hist.push_back(btn);
            if (!btn && m_first_low < 0)
                m_first_low = m_edge;
            m_tick  = (m_state == 1) && (m_cnt >= term_of(rate_sel));
            m_press = filt_after(m_edge - 1) && !filt_after(m_edge - 2)
                      && m_first_low >= 1 && m_first_low <= m_edge - 3;
            m_next = m_state;
            if (stop)
                m_next = 0;
            else if (m_press)
                m_next = (m_state == 1) ? 2 : 1;
            if (m_next == 0)
                m_cnt = 0;
            else if (m_state == 1)
                m_cnt = m_tick ? 0 : m_cnt + 1;
            if (m_next != 0) begin
                if (m_state == 0 || (m_tick && int'(mode) != m_mode)) begin
                    m_mode = int'(mode);
                    m_step = 0;
                end else if (m_tick) begin
                    m_step++;
                end
            end
            m_state = m_next;
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected step outputs are queued as the model predicts each tick
    always @(negedge clk) begin
        #1;
        if (rst_n && m_state == 1 && m_cnt >= term_of(rate_sel))
            sb_q.push_back(model_led());
    end

    always @(negedge clk) begin
        #2;
        checkOutput("led", Led, model_led());
        checkOutput("busy", {3'b000, busy}, {3'b000, m_state != 0});
        checkOutput("tick", {3'b000, tick}, {3'b000, sb_q.size() != 0});
        if (sb_q.size() != 0) begin
            if (tick)
                checkOutput("tick_led", Led, sb_q.pop_front());
            else
                void'(sb_q.pop_front());
        end
    end

    task automatic applyStimulus(input logic b, input logic s, input logic [1:0] md,
                                 input logic [1:0] rs, input int cycles);
        @(negedge clk);
        btn      = b;
        stop     = s;
        mode     = md;
        rate_sel = rs;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic pressButton(input logic [1:0] md, input logic [1:0] rs);
        applyStimulus(1'b1, 1'b0, md, rs, 8);
        applyStimulus(1'b0, 1'b0, md, rs, 4);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] cur_mode;
        logic [1:0] cur_rate;
        int         r;

        btn      = 1'b1;
        stop     = 1'b0;
        mode     = 2'd1;
        rate_sel = 2'd3;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;

        // Button already high at reset release must not start the sequencer
        applyStimulus(1'b1, 1'b0, 2'd1, 2'd3, 12);
        checkOutput("no_press_after_reset", {3'b000, busy}, 4'd0);
        applyStimulus(1'b0, 1'b0, 2'd1, 2'd3, 5);

        pressButton(2'd1, 2'd3);
        applyStimulus(1'b0, 1'b0, 2'd1, 2'd3, 24);
        checkOutput("walk_busy", {3'b000, busy}, 4'd1);

        applyStimulus(1'b0, 1'b1, 2'd2, 2'd3, 3);
        checkOutput("stop_led", Led, 4'd0);
        pressButton(2'd2, 2'd3);
        applyStimulus(1'b0, 1'b0, 2'd2, 2'd3, 30);

        pressButton(2'd2, 2'd3);
        applyStimulus(1'b0, 1'b0, 2'd2, 2'd3, 9);
        checkOutput("pause_busy", {3'b000, busy}, 4'd1);
        pressButton(2'd2, 2'd3);
        applyStimulus(1'b0, 1'b0, 2'd2, 2'd3, 13);

        applyStimulus(1'b1, 1'b1, 2'd2, 2'd3, 12);
        applyStimulus(1'b0, 1'b0, 2'd2, 2'd3, 3);
        checkOutput("stop_wins_busy", {3'b000, busy}, 4'd0);
        checkOutput("stop_wins_led", Led, 4'd0);

        pressButton(2'd3, 2'd3);
        applyStimulus(1'b0, 1'b0, 2'd3, 2'd3, 14);
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd3, 20);

        applyStimulus(1'b0, 1'b1, 2'd1, 2'd3, 2);
        applyStimulus(1'b1, 1'b0, 2'd1, 2'd3, 3);
        applyStimulus(1'b0, 1'b0, 2'd1, 2'd3, 10);
`ifdef LED_SEQ_DEBOUNCE_EN
        checkOutput("glitch_busy", {3'b000, busy}, 4'd0);
`else
        checkOutput("glitch_busy", {3'b000, busy}, 4'd1);
`endif
        applyStimulus(1'b0, 1'b1, 2'd1, 2'd3, 2);

        pressButton(2'd1, 2'd3);
        applyStimulus(1'b0, 1'b0, 2'd1, 2'd3, 15);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_led", Led, 4'd0);
        checkOutput("async_busy", {3'b000, busy}, 4'd0);
        checkOutput("async_tick", {3'b000, tick}, 4'd0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;

        cur_mode = 2'd0;
        cur_rate = 2'd3;
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0)
                cur_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0)
                cur_rate = 2'($urandom_range(0, 3));
            if (r < 5) begin
                applyStimulus(1'b0, 1'b0, cur_mode, cur_rate, int'($urandom_range(1, 40)));
            end else if (r < 8) begin
                applyStimulus(1'b1, 1'b0, cur_mode, cur_rate, int'($urandom_range(1, 10)));
                applyStimulus(1'b0, 1'b0, cur_mode, cur_rate, int'($urandom_range(1, 6)));
            end else if (r == 8) begin
                applyStimulus(1'b0, 1'b1, cur_mode, cur_rate, int'($urandom_range(1, 3)));
            end else begin
                applyStimulus(1'b1, 1'b1, cur_mode, cur_rate, int'($urandom_range(1, 4)));
            end
        end

        applyStimulus(1'b0, 1'b0, cur_mode, cur_rate, 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 Parameter DIV_WIDTH, default 16: prescaler width; minimum 8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable-high cycles required before a press is accepted (used only with LED_SEQ_DEBOUNCE_EN).
REQ-003 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 btn  input  1  raw asynchronous push-button, active high; each accepted press toggles run/pause.
REQ-006 stop  input  1  synchronous, active high; returns the block to IDLE.
REQ-007 mode  input  2  pattern select: 0 = toggle-all, 1 = walking-one, 2 = bounce, 3 = binary-count.
REQ-008 rate_sel  input  2  prescaler terminal select.
REQ-009 Led  output  4  LED drive.
REQ-010 tick  output  1  one-cycle pulse marking each pattern step.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 btn shall pass through a 2-flop synchronizer; a press is the rising edge of the synchronized (and, if enabled, debounced) level.
REQ-013 FSM states IDLE, RUN and PAUSE shall have these transitions on a press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-014 stop high shall force IDLE on the next edge from any state; when stop and a press coincide, stop wins.
REQ-015 Terminal value shall be (2^DIV_WIDTH - 1) >> (2*rate_sel).
REQ-016 In RUN, the prescaler shall increment each cycle; when count >= terminal, tick shall pulse that cycle and count shall return to 0 on the next edge.
REQ-017 Prescaler behaviour outside RUN: held at 0 in IDLE; frozen in PAUSE, resuming from its held value on return to RUN.
REQ-018 tick shall never assert outside RUN.
REQ-019 Lowering rate_sel below the current count shall produce a tick on the next cycle (>= compare), not a wrap through 2^DIV_WIDTH.
REQ-020 On IDLE->RUN, mode shall be latched into mode_q and Led loaded with the initial pattern: mode 0 -> 1111, 1 -> 0001, 2 -> 0001 with direction up, 3 -> 0000.
REQ-021 On each tick with mode == mode_q, Led shall step as follows:
  - mode 0: invert all bits.
  - mode 1: rotate left (1000 -> 0001).
  - mode 2: shift in the current direction; direction reverses on reaching 1000 or 0001, giving 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
  - mode 3: add 1 modulo 16 (1111 -> 0000).
REQ-022 On a tick with mode != mode_q, mode_q shall take the new mode and Led shall load that mode's initial pattern instead of stepping.
REQ-023 Led shall hold its value in PAUSE and be 0000 in IDLE.
REQ-024 Press latency without debounce: with btn high before edge k, the state change shall be visible after edge k+2.
REQ-025 Press latency with debounce: the state change shall be visible DEBOUNCE_CYCLES edges later than in REQ-024.
REQ-026 busy shall be registered to follow the state (it is low in IDLE, high in RUN and PAUSE).

Reset
REQ-027 Asserting rst_n low shall immediately force these values: state IDLE, Led 0000, tick 0, busy 0, prescaler 0, direction up, mode_q 0, synchronizer and debounce registers 0.
REQ-028 Deasserting rst_n shall leave the block in IDLE; a btn level already high at deassertion shall not count as a press until it has gone low and high again.

Configuration
REQ-029 Macro LED_SEQ_DEBOUNCE_EN defined: a counter shall require DEBOUNCE_CYCLES consecutive high synchronized samples before the filtered level rises; any low sample shall clear the counter and the filtered level immediately.
REQ-030 Macro LED_SEQ_DEBOUNCE_EN undefined: the filtered level shall equal the synchronizer output, no debounce logic shall be present, and DEBOUNCE_CYCLES shall be ignored.

Verification (DIV_WIDTH=8, rate_sel=3 -> terminal 3, tick every 4 cycles in RUN; debounce disabled unless stated)
REQ-031 Reset is released, then one btn press in mode 1 -> Led goes 0001, 0010, 0100, 1000, 0001, with tick one cycle every 4 cycles and busy=1.
REQ-032 In mode 2, run 8 ticks -> Led shows 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
REQ-033 In RUN at count 2, press btn -> PAUSE; Led and count frozen, no tick; a second press resumes and gives a tick 1 cycle after RUN re-entry.
REQ-034 stop and a btn press in the same cycle -> IDLE, Led 0000, busy 0; rst_n pulsed low mid-RUN -> all outputs 0 asynchronously.
REQ-035 Mode changed from 3 to 0 mid-RUN -> the next tick loads 1111 and the following tick gives 0000.
REQ-036 With LED_SEQ_DEBOUNCE_EN and DEBOUNCE_CYCLES=4, a 3-cycle btn glitch -> no state change; a 6-cycle press -> IDLE->RUN exactly 4 edges after the non-debounce latency.
